trig_accept_ctrl: RTL and testbench

Run and trigger-acceptance sequencer for the external-trigger path, in the clk40 domain.
- Takes the 8-bit deserialized trigger-phase word and the synchronized busy level.
- Decides per clk40 cycle whether an incoming trigger edge is accepted or vetoed.
- Enforces a programmable deadtime and trigger-count limit.
- Queues {trigger number, phase word} records in a small FIFO for readout over a valid/ready handshake.
- Start/stop and limits come from the AXI parameter registers (already synchronized to clk40).

---
 rtl/trig_accept_ctrl_if.sv | 32 +++
 rtl/trig_accept_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_trig_accept_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trig_accept_ctrl_if.sv
// ---------------------------------------------------------------------------
// trig_accept_ctrl_if
// Event-record readout handshake between the trigger acceptance sequencer
// (master) and its consumer (slave).
//   evt_valid     master -> slave  FIFO head holds a record
//   evt_ready     slave  -> master consumer takes the head this cycle
//   evt_trig_num  master -> slave  1-based trigger number of the record
//   evt_phase     master -> slave  trigger-phase word captured at the edge
// ---------------------------------------------------------------------------
interface trig_accept_ctrl_if #(
  parameter int COUNT_W = 32,
  parameter int PHASE_W = 8
);
  logic               evt_valid;
  logic               evt_ready;
  logic [COUNT_W-1:0] evt_trig_num;
  logic [PHASE_W-1:0] evt_phase;

  modport master (
    output evt_valid,
    output evt_trig_num,
    output evt_phase,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_trig_num,
    input  evt_phase,
    output evt_ready
  );
endinterface

// File: rtl/trig_accept_ctrl.sv
// ---------------------------------------------------------------------------
// trig_accept_ctrl
// Run control and trigger acceptance for the external-trigger path (clk40).
// A rising edge of the OR-reduced trigger-phase word is accepted or vetoed
// each cycle; accepted triggers start a programmable deadtime, bump the
// trigger counter and queue a {trigger number, phase word} record in a small
// first-word-fall-through FIFO read out over evt (valid/ready).
//
// Ports:
//   clk40, reset        clock, synchronous active-high reset
//   start_run/stop_run  run arm / disarm
//   max_triggers        accepted-trigger limit per run (0 = unlimited)
//   deadtime            extra dead cycles after an accept
//   trig_phase          deserialized trigger word, one per cycle
//   busy_in             downstream busy veto
//   trig_accept         one-cycle pulse per accepted trigger
//   running / dead      state indicators (ARMED|DEAD / DEAD)
//   trig_count          accepted triggers this run
//   veto_count          edges rejected while running (saturating)
//   fifo_overflow       sticky: an edge was lost only because the FIFO was full
//   evt                 event-record readout (master modport)
// ---------------------------------------------------------------------------
module trig_accept_ctrl #(
  parameter int COUNT_W    = 32,
  parameter int DEAD_W     = 16,
  parameter int PHASE_W    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk40,
  input  logic               reset,
  input  logic               start_run,
  input  logic               stop_run,
  input  logic [COUNT_W-1:0] max_triggers,
  input  logic [DEAD_W-1:0]  deadtime,
  input  logic [PHASE_W-1:0] trig_phase,
  input  logic               busy_in,
  output logic               trig_accept,
  output logic               running,
  output logic               dead,
  output logic [COUNT_W-1:0] trig_count,
  output logic [31:0]        veto_count,
  output logic               fifo_overflow,
  trig_accept_ctrl_if.master evt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = COUNT_W + PHASE_W;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1_C = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               prev_lvl_q;
  logic [COUNT_W-1:0] trig_count_q, trig_count_d;
  logic [31:0]        veto_count_q, veto_count_d;
  logic               fifo_overflow_q, fifo_overflow_d;
  logic [DEAD_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic               accept_q, accept_d;

  // Accepted record waits one cycle in this stage before entering the FIFO,
  // which places evt_valid two cycles after the edge.
  logic               wr_q, wr_d;
  logic [COUNT_W-1:0] wr_num_q, wr_num_d;
  logic [PHASE_W-1:0] wr_phase_q, wr_phase_d;

  logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   fifo_cnt_q;

  logic               edge_w;
  logic               fifo_full_w;
  logic               push_w;
  logic               pop_w;
  logic [COUNT_W-1:0] trig_count_inc_w;
  logic [31:0]        veto_count_inc_w;
  logic [REC_W-1:0]   head_w;

  assign edge_w           = (|trig_phase) && !prev_lvl_q;
  assign trig_count_inc_w = trig_count_q + COUNT_W'(1);
  assign veto_count_inc_w = (veto_count_q == 32'hFFFF_FFFF) ? veto_count_q
                                                            : veto_count_q + 32'd1;

  // A record still sitting in the write stage already owns a FIFO slot.
  assign fifo_full_w = (fifo_cnt_q == DEPTH_C) ||
                       (wr_q && (fifo_cnt_q == DEPTH_M1_C));

  // Full is judged before any same-cycle pop, so a full FIFO never takes a write.
  assign push_w = wr_q && (fifo_cnt_q != DEPTH_C);
  assign pop_w  = evt.evt_ready && (fifo_cnt_q != '0);

  // -------------------------------------------------------------------------
  // Sequencer next-state / outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    trig_count_d    = trig_count_q;
    veto_count_d    = veto_count_q;
    fifo_overflow_d = fifo_overflow_q;
    dead_cnt_d      = dead_cnt_q;
    accept_d        = 1'b0;
    wr_d            = 1'b0;
    wr_num_d        = wr_num_q;
    wr_phase_d      = wr_phase_q;

    case (state_q)
      S_IDLE: begin
        if (start_run && !stop_run) begin
          state_d         = S_ARMED;
          trig_count_d    = '0;
          veto_count_d    = '0;
          fifo_overflow_d = 1'b0;
        end
      end

      S_ARMED: begin
        if (stop_run) begin
          // Stop wins: a coincident edge is dropped without being counted.
          state_d = S_IDLE;
        end else if (edge_w) begin
          if (busy_in || fifo_full_w) begin
            veto_count_d = veto_count_inc_w;
            if (fifo_full_w && !busy_in) begin
              fifo_overflow_d = 1'b1;
            end
          end else begin
            accept_d     = 1'b1;
            trig_count_d = trig_count_inc_w;
            wr_d         = 1'b1;
            wr_num_d     = trig_count_inc_w;
            wr_phase_d   = trig_phase;
            dead_cnt_d   = deadtime;
            if ((max_triggers != '0) && (trig_count_inc_w == max_triggers)) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DEAD;
            end
          end
        end
      end

      S_DEAD: begin
        if (stop_run) begin
          state_d = S_IDLE;
        end else begin
          if (edge_w) begin
            veto_count_d = veto_count_inc_w;
          end
          // Counter loaded with D gives D+1 dead cycles.
          if (dead_cnt_q == '0) begin
            state_d = S_ARMED;
          end else begin
            dead_cnt_d = dead_cnt_q - DEAD_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      state_q         <= S_IDLE;
      prev_lvl_q      <= 1'b0;
      trig_count_q    <= '0;
      veto_count_q    <= '0;
      fifo_overflow_q <= 1'b0;
      dead_cnt_q      <= '0;
      accept_q        <= 1'b0;
      wr_q            <= 1'b0;
      wr_num_q        <= '0;
      wr_phase_q      <= '0;
    end else begin
      state_q         <= state_d;
      prev_lvl_q      <= |trig_phase;
      trig_count_q    <= trig_count_d;
      veto_count_q    <= veto_count_d;
      fifo_overflow_q <= fifo_overflow_d;
      dead_cnt_q      <= dead_cnt_d;
      accept_q        <= accept_d;
      wr_q            <= wr_d;
      wr_num_q        <= wr_num_d;
      wr_phase_q      <= wr_phase_d;
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk40) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_w) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop_w) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push_w) - CNT_W'(pop_w);
    end
  end

  // Storage has no reset; reset only clears the pointers and occupancy.
  always_ff @(posedge clk40) begin
    if (push_w) begin
      mem_q[wptr_q] <= {wr_num_q, wr_phase_q};
    end
  end

  // Head read is asynchronous so the record is presented as soon as it lands;
  // writes never target the head slot while it is valid, so it holds steady.
  assign head_w = mem_q[rptr_q];

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign trig_accept   = accept_q;
  assign running       = (state_q == S_ARMED) || (state_q == S_DEAD);
  assign dead          = (state_q == S_DEAD);
  assign trig_count    = trig_count_q;
  assign veto_count    = veto_count_q;
  assign fifo_overflow = fifo_overflow_q;

  assign evt.evt_valid    = (fifo_cnt_q != '0);
  // Data forced to zero when empty so unwritten storage never shows up.
  assign evt.evt_trig_num = evt.evt_valid ? head_w[REC_W-1:PHASE_W] : '0;
  assign evt.evt_phase    = evt.evt_valid ? head_w[PHASE_W-1:0]     : '0;

endmodule

// File: tb/tb_trig_accept_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trig_accept_ctrl
// Directed bench for trig_accept_ctrl. Inputs change 1 ns after each rising
// clk40 edge and outputs are sampled at the same point, so "cycle k" below
// means the interval following rising edge k.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trig_accept_ctrl;

  logic        clk40;
  logic        reset;
  logic        start_run;
  logic        stop_run;
  logic [31:0] max_triggers;
  logic [15:0] deadtime;
  logic [7:0]  trig_phase;
  logic        busy_in;
  logic        trig_accept;
  logic        running;
  logic        dead;
  logic [31:0] trig_count;
  logic [31:0] veto_count;
  logic        fifo_overflow;

  int checks;
  int errors;

  trig_accept_ctrl_if #(.COUNT_W(32), .PHASE_W(8)) evt_if ();

  trig_accept_ctrl #(
    .COUNT_W   (32),
    .DEAD_W    (16),
    .PHASE_W   (8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk40        (clk40),
    .reset        (reset),
    .start_run    (start_run),
    .stop_run     (stop_run),
    .max_triggers (max_triggers),
    .deadtime     (deadtime),
    .trig_phase   (trig_phase),
    .busy_in      (busy_in),
    .trig_accept  (trig_accept),
    .running      (running),
    .dead         (dead),
    .trig_count   (trig_count),
    .veto_count   (veto_count),
    .fifo_overflow(fifo_overflow),
    .evt          (evt_if.master)
  );

  initial clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic apply_reset();
    reset            = 1'b1;
    start_run        = 1'b0;
    stop_run         = 1'b0;
    max_triggers     = 32'd0;
    deadtime         = 16'd0;
    trig_phase       = 8'h00;
    busy_in          = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    checks++; if (trig_accept !== 1'b0) begin errors++; $display("FAIL reset_trig_accept: got %0b expected 0", trig_accept); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", running); end
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL reset_dead: got %0b expected 0", dead); end
    checks++; if (trig_count !== 32'd0) begin errors++; $display("FAIL reset_trig_count: got %0d expected 0", trig_count); end
    checks++; if (veto_count !== 32'd0) begin errors++; $display("FAIL reset_veto_count: got %0d expected 0", veto_count); end
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_fifo_overflow: got %0b expected 0", fifo_overflow); end
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid: got %0b expected 0", evt_if.evt_valid); end
    $display("test_reset done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_basic_accept();
    apply_reset();
    deadtime  = 16'd3;
    start_run = 1'b1;                  // cycle 0
    tick();                            // cycle 1
    start_run = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL basic_running_after_start: got %0b expected 1", running); end
    repeat (9) tick();                 // cycle 10
    trig_phase = 8'hF0;
    tick();                            // cycle 11
    trig_phase = 8'h00;
    checks++; if (trig_accept !== 1'b1) begin errors++; $display("FAIL basic_accept_c11: got %0b expected 1", trig_accept); end
    checks++; if (dead !== 1'b1) begin errors++; $display("FAIL basic_dead_c11: got %0b expected 1", dead); end
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL basic_evt_valid_c11: got %0b expected 0", evt_if.evt_valid); end
    tick();                            // cycle 12
    checks++; if (trig_accept !== 1'b0) begin errors++; $display("FAIL basic_accept_c12: got %0b expected 0", trig_accept); end
    checks++; if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL basic_evt_valid_c12: got %0b expected 1", evt_if.evt_valid); end
    checks++; if (evt_if.evt_trig_num !== 32'd1) begin errors++; $display("FAIL basic_trig_num: got %0d expected 1", evt_if.evt_trig_num); end
    checks++; if (evt_if.evt_phase !== 8'hF0) begin errors++; $display("FAIL basic_phase: got %0h expected f0", evt_if.evt_phase); end
    checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL basic_trig_count: got %0d expected 1", trig_count); end
    tick();                            // cycle 13
    tick();                            // cycle 14
    checks++; if (dead !== 1'b1) begin errors++; $display("FAIL basic_dead_c14: got %0b expected 1", dead); end
    tick();                            // cycle 15
    checks++; if (dead !== 1'b0) begin errors++; $display("FAIL basic_dead_c15: got %0b expected 0", dead); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL basic_running_c15: got %0b expected 1", running); end
    $display("test_basic_accept: trig_num=%0d phase=%0h", evt_if.evt_trig_num, evt_if.evt_phase);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_deadtime_veto();
    apply_reset();
    deadtime = 16'd3;
    start_pulse();
    tick();
    trig_phase = 8'h01;                // edge, cycle A
    tick();                            // A+1: accept, dead until A+4
    trig_phase = 8'h00;
    tick();                            // A+2
    tick();                            // A+3
    trig_phase = 8'h01;                // edge inside deadtime
    tick();                            // A+4
    trig_phase = 8'h00;
    checks++; if (trig_accept !== 1'b0) begin errors++; $display("FAIL deadveto_accept: got %0b expected 0", trig_accept); end
    checks++; if (veto_count !== 32'd1) begin errors++; $display("FAIL deadveto_veto_count: got %0d expected 1", veto_count); end
    checks++; if (trig_count !== 32'd1) begin errors++; $display("FAIL deadveto_trig_count: got %0d expected 1", trig_count); end
    $display("test_deadtime_veto: veto_count=%0d", veto_count);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_busy_overflow();
    int accepts;
    apply_reset();
    deadtime = 16'd0;
    start_pulse();
    busy_in    = 1'b1;
    trig_phase = 8'h01;
    tick();
    busy_in    = 1'b0;
    trig_phase = 8'h00;
    checks++; if (trig_accept !== 1'b0) begin errors++; $display("FAIL busy_accept: got %0b expected 0", trig_accept); end
    checks++; if (veto_count !== 32'd1) begin errors++; $display("FAIL busy_veto_count: got %0d expected 1", veto_count); end
    checks++; if (fifo_overflow !== 1'b0) begin errors++; $display("FAIL busy_overflow: got %0b expected 0", fifo_overflow); end
    tick();
    accepts = 0;
    for (int i = 0; i < 16; i++) begin
      trig_phase = 8'(i + 1);
      tick();
      if (trig_accept === 1'b1) accepts++;
      trig_phase = 8'h00;
      tick();
    end
    checks++; if (accepts !== 16) begin errors++; $display("FAIL fill_accepts: got %0d expected 16", accepts); end
    checks++; if (trig_count !== 32'd16) begin errors++; $display("FAIL fill_trig_count: got %0d expected 16", trig_count); end
    trig_phase = 8'h55;                // 17th edge, FIFO full
    tick();
    trig_phase = 8'h00;
    checks++; if (trig_accept !== 1'b0) begin errors++; $display("FAIL full_accept: got %0b expected 0", trig_accept); end
    checks++; if (veto_count !== 32'd2) begin errors++; $display("FAIL full_veto_count: got %0d expected 2", veto_count); end
    checks++; if (fifo_overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %0b expected 1", fifo_overflow); end
    checks++; if (evt_if.evt_trig_num !== 32'd1) begin errors++; $display("FAIL full_head_num: got %0d expected 1", evt_if.evt_trig_num); end
    $display("test_busy_overflow: accepts=%0d veto_count=%0d", accepts, veto_count);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_limit();
    int pulses;
    apply_reset();
    max_triggers     = 32'd3;
    deadtime         = 16'd1;
    evt_if.evt_ready = 1'b1;
    start_pulse();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      trig_phase = 8'h80;
      tick();
      trig_phase = 8'h00;
      if (trig_accept === 1'b1) begin
        pulses++;
        if (pulses == 3) begin
          checks++; if (running !== 1'b0) begin errors++; $display("FAIL limit_running_after_3rd: got %0b expected 0", running); end
        end
      end
      repeat (4) tick();
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL limit_pulses: got %0d expected 3", pulses); end
    checks++; if (trig_count !== 32'd3) begin errors++; $display("FAIL limit_trig_count: got %0d expected 3", trig_count); end
    checks++; if (veto_count !== 32'd0) begin errors++; $display("FAIL limit_veto_count: got %0d expected 0", veto_count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL limit_running_end: got %0b expected 0", running); end
    max_triggers     = 32'd0;
    evt_if.evt_ready = 1'b0;
    $display("test_limit: pulses=%0d", pulses);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_simultaneous();
    apply_reset();
    start_pulse();
    tick();
    trig_phase = 8'h0F;
    stop_run   = 1'b1;
    tick();
    trig_phase = 8'h00;
    stop_run   = 1'b0;
    checks++; if (trig_accept !== 1'b0) begin errors++; $display("FAIL stop_edge_accept: got %0b expected 0", trig_accept); end
    checks++; if (veto_count !== 32'd0) begin errors++; $display("FAIL stop_edge_veto_count: got %0d expected 0", veto_count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_edge_running: got %0b expected 0", running); end
    checks++; if (trig_count !== 32'd0) begin errors++; $display("FAIL stop_edge_trig_count: got %0d expected 0", trig_count); end
    start_run = 1'b1;
    stop_run  = 1'b1;
    tick();
    start_run = 1'b0;
    stop_run  = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_stop_running: got %0b expected 0", running); end
    $display("test_simultaneous done");
  endtask

  // -------------------------------------------------------------------------
  task automatic test_handshake_reset();
    logic [7:0] ph [3];
    ph[0] = 8'h11;
    ph[1] = 8'h22;
    ph[2] = 8'h33;
    apply_reset();
    start_pulse();
    for (int i = 0; i < 3; i++) begin
      trig_phase = ph[i];
      tick();
      trig_phase = 8'h00;
      tick();
    end
    checks++; if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL hs_valid_1: got %0b expected 1", evt_if.evt_valid); end
    checks++; if (evt_if.evt_trig_num !== 32'd1) begin errors++; $display("FAIL hs_num_1: got %0d expected 1", evt_if.evt_trig_num); end
    checks++; if (evt_if.evt_phase !== 8'h11) begin errors++; $display("FAIL hs_phase_1: got %0h expected 11", evt_if.evt_phase); end
    $display("pop trig_num=%0d phase=%0h", evt_if.evt_trig_num, evt_if.evt_phase);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    checks++; if (evt_if.evt_trig_num !== 32'd2) begin errors++; $display("FAIL hs_num_2: got %0d expected 2", evt_if.evt_trig_num); end
    tick();
    checks++; if (evt_if.evt_trig_num !== 32'd2) begin errors++; $display("FAIL hs_hold_num_2: got %0d expected 2", evt_if.evt_trig_num); end
    checks++; if (evt_if.evt_phase !== 8'h22) begin errors++; $display("FAIL hs_hold_phase_2: got %0h expected 22", evt_if.evt_phase); end
    $display("pop trig_num=%0d phase=%0h", evt_if.evt_trig_num, evt_if.evt_phase);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    checks++; if (evt_if.evt_trig_num !== 32'd3) begin errors++; $display("FAIL hs_num_3: got %0d expected 3", evt_if.evt_trig_num); end
    checks++; if (evt_if.evt_phase !== 8'h33) begin errors++; $display("FAIL hs_phase_3: got %0h expected 33", evt_if.evt_phase); end
    $display("pop trig_num=%0d phase=%0h", evt_if.evt_trig_num, evt_if.evt_phase);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL hs_empty: got %0b expected 0", evt_if.evt_valid); end

    for (int i = 0; i < 2; i++) begin
      trig_phase = 8'hA0;
      tick();
      trig_phase = 8'h00;
      tick();
    end
    checks++; if (evt_if.evt_valid !== 1'b1) begin errors++; $display("FAIL hs_requeued_valid: got %0b expected 1", evt_if.evt_valid); end
    checks++; if (evt_if.evt_trig_num !== 32'd4) begin errors++; $display("FAIL hs_requeued_num: got %0d expected 4", evt_if.evt_trig_num); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (evt_if.evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid: got %0b expected 0", evt_if.evt_valid); end
    checks++; if (trig_count !== 32'd0) begin errors++; $display("FAIL rst_trig_count: got %0d expected 0", trig_count); end
    checks++; if (veto_count !== 32'd0) begin errors++; $display("FAIL rst_veto_count: got %0d expected 0", veto_count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %0b expected 0", running); end
    $display("test_handshake_reset done");
  endtask

  // -------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_accept();
    test_deadtime_veto();
    test_busy_overflow();
    test_limit();
    test_simultaneous();
    test_handshake_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
